pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register, successor to the fixed-field inter-stage registers (ID/EXE, EXE/MEM, MEM/WB).
- Carries an opaque data bundle and a control bundle between two pipeline stages.
- Adds a valid/ready handshake, synchronous flush, bubble insertion with zeroed control, and a saturating stall counter.
- Every stage boundary of the forwarding pipeline instantiates one copy, with widths set per boundary.

---
 rtl/pipe_stage_reg.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register carrying a data and a control bundle with valid/ready.
// Latency: 1 cycle from upstream acceptance to out_* when the stage is empty or draining.
// Backpressure: holds stable while out_ready_i=0; ready is combinational, or registered with PIPE_STAGE_SKID_EN.
//
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid buffer.
// With the skid buffer, in_ready_o comes from a flop instead of the downstream ready path.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Main output register
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Stall statistics
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Handshake events at the coming edge; an entry offered during flush is consumed and dropped
  logic up_xfer;
  logic dn_xfer;
  logic stalled;

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry, only written while the main register is full and stalled
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

  // Ready depends only on skid occupancy, plus the flush override
  assign in_ready_o = flush_i | ~skid_valid_q;
`else
  // Ready when empty or when the held entry leaves this cycle, plus the flush override
  assign in_ready_o = flush_i | ~valid_q | out_ready_i;
`endif

  assign up_xfer = in_valid_i & in_ready_o & ~flush_i;
  assign dn_xfer = valid_q & out_ready_i;
  assign stalled = valid_q & ~out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
  // Next-state for main and skid entries; flush wins over every handshake
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!valid_q || dn_xfer) begin
      // Main register is free this edge: refill from skid first to keep order
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        ctrl_d       = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (up_xfer) begin
        valid_d = 1'b1;
        data_d  = in_data_i;
        ctrl_d  = in_ctrl_i;
      end else begin
        // Drained with nothing behind it; data is left as-is, control is zeroed
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end else if (up_xfer) begin
      // Main register is held by a stall: park the incoming entry in the skid slot
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
      skid_ctrl_d  = in_ctrl_i;
    end
  end
`else
  // Next-state for the main entry; flush wins over every handshake
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (up_xfer && (!valid_q || dn_xfer)) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      ctrl_d  = in_ctrl_i;
    end else if (dn_xfer) begin
      // Drained with nothing behind it; data is left as-is, control is zeroed
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
`endif

  // Saturating stall counter; clear beats increment, flush leaves it alone
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr_i) begin
      cnt_d = '0;
    end else if (stalled && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Main entry and counter state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`endif

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ctrl_o  = ctrl_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, counter clear/saturation, async reset.
// A second instance with a 4-bit counter shares all stimulus and is used for the saturation case.
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 8;

  logic              clk_i;
  logic              rst_n_i;
  logic              flush_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_ready_i;
  logic              stat_clr_i;

  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [15:0]       stall_cnt_o;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [3:0]        s_stall_cnt;

  int n_vec;
  int n_err;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ctrl_o  (out_ctrl_o),
    .stat_clr_i  (stat_clr_i),
    .stall_cnt_o (stall_cnt_o)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (s_in_ready),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .out_valid_o (s_out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (s_out_data),
    .out_ctrl_o  (s_out_ctrl),
    .stat_clr_i  (stat_clr_i),
    .stall_cnt_o (s_stall_cnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observed value with its expected value and report any miscompare
  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n_i     = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_ctrl_i   = '0;
    out_ready_i = 1'b0;
    stat_clr_i  = 1'b0;

    // Reset state
    #2;
    chk_eq("rst_valid", 128'(out_valid_o), 128'(0));
    chk_eq("rst_data",  128'(out_data_o),  128'(0));
    chk_eq("rst_ctrl",  128'(out_ctrl_o),  128'(0));
    chk_eq("rst_cnt",   128'(stall_cnt_o), 128'(0));
    step();
    rst_n_i = 1'b1;
    #1;
    chk_eq("rst_ready", 128'(in_ready_o), 128'(1));

    // 1. Stream 1,2,3 with the downstream always ready
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data_i = DATA_W'(i);
      in_ctrl_i = CTRL_W'(8'h10 + i);
      step();
      chk_eq($sformatf("stream_valid%0d", i), 128'(out_valid_o), 128'(1));
      chk_eq($sformatf("stream_data%0d", i),  128'(out_data_o),  128'(i));
      chk_eq($sformatf("stream_ctrl%0d", i),  128'(out_ctrl_o),  128'(8'h10 + i));
    end
    in_valid_i = 1'b0;
    step();
    chk_eq("drain_valid", 128'(out_valid_o), 128'(0));
    chk_eq("drain_ctrl",  128'(out_ctrl_o),  128'(0));
    chk_eq("drain_data",  128'(out_data_o),  128'(3));

    // 2. Backpressure on 0xA with 0xB offered behind it
    stat_clr_i = 1'b1;
    step();
    stat_clr_i = 1'b0;
    chk_eq("clr_cnt", 128'(stall_cnt_o), 128'(0));
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = DATA_W'(32'hA);
    in_ctrl_i   = 8'h05;
    step();
    chk_eq("bp_load", 128'(out_data_o), 128'(32'hA));
    in_data_i = DATA_W'(32'hB);
    in_ctrl_i = 8'h06;
    for (int i = 0; i < 4; i++) step();
    chk_eq("bp_hold_data", 128'(out_data_o),  128'(32'hA));
    chk_eq("bp_hold_ctrl", 128'(out_ctrl_o),  128'(8'h05));
    chk_eq("bp_cnt4",      128'(stall_cnt_o), 128'(4));
    chk_eq("bp_ready",     128'(in_ready_o),  128'(0));
    out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk_eq("bp_next_data", 128'(out_data_o),  128'(32'hB));
    chk_eq("bp_next_ctrl", 128'(out_ctrl_o),  128'(8'h06));
    chk_eq("bp_cnt_hold",  128'(stall_cnt_o), 128'(4));
    step();
    chk_eq("bp_empty", 128'(out_valid_o), 128'(0));

    // 3. Flush kills the held 0xC and the incoming 0xD with ctrl 0xFF
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = DATA_W'(32'hC);
    in_ctrl_i   = 8'h33;
    step();
    chk_eq("fl_load", 128'(out_data_o), 128'(32'hC));
    flush_i   = 1'b1;
    in_data_i = DATA_W'(32'hD);
    in_ctrl_i = 8'hFF;
    #1;
    chk_eq("fl_ready", 128'(in_ready_o), 128'(1));
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk_eq("fl_valid", 128'(out_valid_o), 128'(0));
    chk_eq("fl_ctrl",  128'(out_ctrl_o),  128'(0));
    chk_eq("fl_cnt",   128'(stall_cnt_o), 128'(5));
    out_ready_i = 1'b1;
    step();
    chk_eq("fl_never", 128'(out_valid_o), 128'(0));

    // 4. Flush together with counter clear while stalled
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = DATA_W'(32'hE);
    in_ctrl_i   = 8'h44;
    step();
    in_valid_i = 1'b0;
    step();
    chk_eq("fc_cnt6", 128'(stall_cnt_o), 128'(6));
    flush_i    = 1'b1;
    stat_clr_i = 1'b1;
    step();
    flush_i    = 1'b0;
    stat_clr_i = 1'b0;
    chk_eq("fc_valid", 128'(out_valid_o), 128'(0));
    chk_eq("fc_cnt",   128'(stall_cnt_o), 128'(0));

    // 5. Stall 20 cycles: 16-bit counter reads 20, 4-bit counter saturates at 0xF
    in_valid_i = 1'b1;
    in_data_i  = DATA_W'(32'hF);
    in_ctrl_i  = 8'h77;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk_eq("sat_cnt16", 128'(stall_cnt_o), 128'(20));
    chk_eq("sat_cnt4",  128'(s_stall_cnt), 128'(4'hF));
    chk_eq("sat_data",  128'(out_data_o),  128'(32'hF));

    // 6. Asynchronous reset between edges while stalled
    #3;
    rst_n_i = 1'b0;
    #1;
    chk_eq("ar_valid", 128'(out_valid_o), 128'(0));
    chk_eq("ar_ctrl",  128'(out_ctrl_o),  128'(0));
    chk_eq("ar_data",  128'(out_data_o),  128'(0));
    chk_eq("ar_cnt",   128'(stall_cnt_o), 128'(0));
    chk_eq("ar_cnt4",  128'(s_stall_cnt), 128'(0));
    step();
    rst_n_i = 1'b1;

    // Recovery after reset: one entry passes through
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = DATA_W'(32'h77);
    in_ctrl_i   = 8'h21;
    step();
    in_valid_i = 1'b0;
    chk_eq("rec_data",  128'(out_data_o), 128'(32'h77));
    chk_eq("rec_valid", 128'(out_valid_o), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
